// File: rtl/multicycle_control_if.sv
// multicycle_control_if: memory handshakes, datapath enables and status of the multicycle sequencer
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             Imem_Ready;
  logic [31:0]      Instruction;
  logic             Dmem_Ready;
  logic             Zero;
  logic             Imem_Req;
  logic             Dmem_Req;
  logic             Mem_Read;
  logic             Mem_Write;
  logic             IR_Write;
  logic             PC_Write;
  logic             PC_Src;
  logic             ALU_SrcB;
  logic [1:0]       Operation;
  logic [3:0]       Funct_Code;
  logic [2:0]       Funct_3;
  logic             Reg_Write;
  logic             Mem_To_Reg;
  logic [1:0]       Fault;
  logic [CNT_W-1:0] Retired;
  modport master (
    input  Imem_Ready, Instruction, Dmem_Ready, Zero,
    output Imem_Req, Dmem_Req, Mem_Read, Mem_Write, IR_Write, PC_Write, PC_Src, ALU_SrcB,
           Operation, Funct_Code, Funct_3, Reg_Write, Mem_To_Reg, Fault, Retired
  );
  modport slave (
    output Imem_Ready, Instruction, Dmem_Ready, Zero,
    input  Imem_Req, Dmem_Req, Mem_Read, Mem_Write, IR_Write, PC_Write, PC_Src, ALU_SrcB,
           Operation, Funct_Code, Funct_3, Reg_Write, Mem_To_Reg, Fault, Retired
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/exec/mem/wb sequencer for the RV-subset datapath
module multicycle_control #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input logic Clock,
  input logic Reset_n,
  multicycle_control_if.master bus
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, next;
  logic [10:0] ir;
  logic [1:0] fault;
  logic [CNT_W-1:0] retired;
  logic [WW-1:0] wait_cnt;
  logic [6:0] op;
  logic [2:0] f3;
  logic [1:0] op_class;
  logic is_r, is_i, is_ld, is_sd, is_beq, legal, active, req, rdy, waiting, timeout;
  logic ir_write, pc_write, pc_src, reg_write, retire;
  logic instr_unused;
  // only the opcode, funct3 and bit 30 matter to sequencing, so only those are kept
  assign instr_unused = ^{bus.Instruction[31], bus.Instruction[29:15], bus.Instruction[11:7]};
  assign op = ir[6:0];
  assign f3 = ir[9:7];
  assign is_r = op == 7'b0110011;
  assign is_i = op == 7'b0010011 && (f3 == 3'b000 || f3 == 3'b110);
  assign is_ld = op == 7'b0000011 && f3 == 3'b011;
  assign is_sd = op == 7'b0100011 && f3 == 3'b011;
  assign is_beq = op == 7'b1100011 && f3 == 3'b000;
  assign legal = is_r | is_i | is_ld | is_sd | is_beq;
  assign op_class = is_beq ? 2'b01 : is_r ? 2'b10 : is_i ? 2'b11 : 2'b00;
  assign active = state == EXEC || state == MEM || state == WB;
  assign req = state == FETCH || state == MEM;
  assign rdy = state == FETCH ? bus.Imem_Ready : bus.Dmem_Ready;
  assign waiting = req && !rdy;
  // a Ready arriving on the last allowed cycle still completes the access
  assign timeout = waiting && wait_cnt == WW'(WAIT_LIMIT - 1);
  always_comb begin
    next = state;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 1'b0;
    reg_write = 1'b0;
    retire = 1'b0;
    case (state)
      FETCH: if (bus.Imem_Ready) begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        next = DECODE;
      end
      DECODE: next = legal ? EXEC : HALT;
      EXEC: begin
        pc_write = is_beq & bus.Zero;
        pc_src = is_beq;
        retire = is_beq;
        next = is_beq ? FETCH : (is_ld | is_sd) ? MEM : WB;
      end
      MEM: if (bus.Dmem_Ready) begin
        retire = is_sd;
        next = is_sd ? FETCH : WB;
      end
      WB: begin
        reg_write = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      default: next = HALT;
    endcase
    if (timeout) next = HALT;
  end
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= FETCH;
      ir <= '0;
      fault <= 2'b00;
      retired <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next;
      if (ir_write) ir <= {bus.Instruction[30], bus.Instruction[14:12], bus.Instruction[6:0]};
      if (retire) retired <= retired + CNT_W'(1);
      if (state == DECODE && !legal) fault <= 2'b01;
      else if (timeout) fault <= 2'b10;
      wait_cnt <= waiting ? wait_cnt + WW'(1) : '0;
    end
  end
  assign bus.Imem_Req = Reset_n && state == FETCH;
  assign bus.Dmem_Req = Reset_n && state == MEM;
  assign bus.Mem_Read = Reset_n && state == MEM && is_ld;
  assign bus.Mem_Write = Reset_n && state == MEM && is_sd;
  assign bus.IR_Write = Reset_n && ir_write;
  assign bus.PC_Write = Reset_n && pc_write;
  assign bus.PC_Src = Reset_n && pc_src;
  assign bus.ALU_SrcB = Reset_n && active && (is_i | is_ld | is_sd);
  assign bus.Operation = Reset_n && active ? op_class : 2'b00;
  assign bus.Funct_Code = Reset_n && active ? {ir[10], f3} : 4'b0000;
  assign bus.Funct_3 = Reset_n && active ? f3 : 3'b000;
  assign bus.Reg_Write = Reset_n && reg_write;
  assign bus.Mem_To_Reg = Reset_n && state == WB && is_ld;
  assign bus.Fault = Reset_n ? fault : 2'b00;
  assign bus.Retired = Reset_n ? retired : '0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction stream; expected events queued at issue, checked by a monitor
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control #(.WAIT_LIMIT(4), .CNT_W(32)) dut (.Clock(clk), .Reset_n(rst_n), .bus(bus));
  typedef struct {
    string name;
    int kind;
    int cyc;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int icyc = 0;
  logic prev_imem = 1'b0;
  logic [1:0] prev_fault = 2'b00;
  localparam int K_FETCH = 1, K_MEM = 2, K_BR = 3, K_WB = 4, K_FAULT = 5, K_RST = 6;
  function automatic logic [31:0] f_fetch(int ret);
    return {12'b0, 1'b1, 1'b0, 2'b00, 16'(ret)};
  endfunction
  function automatic logic [31:0] f_mem(logic rd, logic wr);
    return {24'b0, rd, wr, 1'b1, 2'b00, 3'b011};
  endfunction
  function automatic logic [31:0] f_br(logic pcw);
    return {25'b0, pcw, 1'b1, 1'b0, 4'b0000};
  endfunction
  function automatic logic [31:0] f_wb(logic [1:0] opc, logic [3:0] fc, logic srcb, logic m2r, int ret);
    return {16'b0, opc, fc, srcb, m2r, 8'(ret)};
  endfunction
  task automatic expect_ev(string n, int k, int c, logic [31:0] d);
    ev_t e;
    e.name = n;
    e.kind = k;
    e.cyc = c;
    e.data = d;
    exp_q.push_back(e);
  endtask
  task automatic observe(int k, int c, logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%h, required no event", k, c, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != c || e.data != d) begin
        failures++;
        $display("FAIL %s: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                 e.name, k, c, d, e.kind, e.cyc, e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      observe(K_RST, 0, {16'b0, bus.Fault, |bus.Retired, bus.Imem_Req, bus.Dmem_Req, bus.Mem_Read,
                         bus.Mem_Write, bus.IR_Write, bus.PC_Write, bus.PC_Src, bus.ALU_SrcB, bus.Reg_Write,
                         bus.Mem_To_Reg, |bus.Operation, |bus.Funct_Code, |bus.Funct_3});
      prev_imem = 1'b0;
      prev_fault = 2'b00;
      icyc = 0;
    end else begin
      icyc = (bus.Imem_Req && !prev_imem) ? 1 : icyc + 1;
      prev_imem = bus.Imem_Req;
      if (bus.IR_Write) observe(K_FETCH, icyc, {12'b0, bus.PC_Write, bus.PC_Src, bus.Fault, bus.Retired[15:0]});
      if (bus.Dmem_Req && bus.Dmem_Ready)
        observe(K_MEM, icyc, {24'b0, bus.Mem_Read, bus.Mem_Write, bus.ALU_SrcB, bus.Operation, bus.Funct_3});
      if (bus.Operation == 2'b01) observe(K_BR, icyc, {25'b0, bus.PC_Write, bus.PC_Src, bus.ALU_SrcB, bus.Funct_Code});
      if (bus.Reg_Write)
        observe(K_WB, icyc, {16'b0, bus.Operation, bus.Funct_Code, bus.ALU_SrcB, bus.Mem_To_Reg, bus.Retired[7:0]});
      if (bus.Fault != prev_fault) observe(K_FAULT, icyc, {30'b0, bus.Fault});
      prev_fault = bus.Fault;
    end
  end
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(string n);
    rst_n = 1'b0;
    expect_ev(n, K_RST, 0, 32'h0);
    step(1);
    rst_n = 1'b1;
  endtask
  task automatic run_alu(string n, logic [31:0] instr, logic [1:0] opc, logic [3:0] fc, logic srcb, int ret);
    bus.Instruction = instr;
    expect_ev({n, "_fetch"}, K_FETCH, 1, f_fetch(ret));
    expect_ev({n, "_wb"}, K_WB, 4, f_wb(opc, fc, srcb, 1'b0, ret));
    step(4);
  endtask
  task automatic run_mem(string n, logic [31:0] instr, logic ld, int late, int ret);
    bus.Instruction = instr;
    bus.Dmem_Ready = 1'b0;
    expect_ev({n, "_fetch"}, K_FETCH, 1, f_fetch(ret));
    expect_ev({n, "_mem"}, K_MEM, 4 + late, f_mem(ld, !ld));
    if (ld) expect_ev({n, "_wb"}, K_WB, 5 + late, f_wb(2'b00, 4'b0011, 1'b1, 1'b1, ret));
    step(3 + late);
    bus.Dmem_Ready = 1'b1;
    step(ld ? 2 : 1);
  endtask
  task automatic run_beq(string n, logic z, int ret);
    bus.Instruction = 32'h00208063;
    bus.Zero = z;
    expect_ev({n, "_fetch"}, K_FETCH, 1, f_fetch(ret));
    expect_ev({n, "_branch"}, K_BR, 3, f_br(z));
    step(3);
  endtask
  task automatic run_illegal(string n, logic [31:0] instr);
    bus.Instruction = instr;
    expect_ev({n, "_fetch"}, K_FETCH, 1, f_fetch(0));
    expect_ev({n, "_fault"}, K_FAULT, 3, 32'h1);
    step(8);
  endtask
  initial begin
    ev_t e;
    bus.Imem_Ready = 1'b1;
    bus.Instruction = 32'h0;
    bus.Dmem_Ready = 1'b1;
    bus.Zero = 1'b0;
    @(posedge clk);
    #1;
    expect_ev("reset_a", K_RST, 0, 32'h0);
    expect_ev("reset_b", K_RST, 0, 32'h0);
    step(2);
    rst_n = 1'b1;
    run_alu("add", 32'h002081B3, 2'b10, 4'b0000, 1'b0, 0);
    run_alu("sub", 32'h402081B3, 2'b10, 4'b1000, 1'b0, 1);
    run_alu("srl", 32'h0020D1B3, 2'b10, 4'b0101, 1'b0, 2);
    run_alu("addi", 32'h00508193, 2'b11, 4'b0000, 1'b1, 3);
    run_alu("ori", 32'h0050E193, 2'b11, 4'b0110, 1'b1, 4);
    run_mem("ld_late3", 32'h0000B183, 1'b1, 3, 5);
    run_mem("sd", 32'h0020B023, 1'b0, 0, 6);
    run_beq("beq_taken", 1'b1, 7);
    run_beq("beq_not_taken", 1'b0, 8);
    bus.Instruction = 32'h0020B023;
    bus.Dmem_Ready = 1'b0;
    expect_ev("sd_abort_fetch", K_FETCH, 1, f_fetch(9));
    step(4);
    do_reset("reset_mid_sd");
    bus.Dmem_Ready = 1'b1;
    run_alu("add_after_reset", 32'h002081B3, 2'b10, 4'b0000, 1'b0, 0);
    bus.Instruction = 32'h0020B023;
    bus.Dmem_Ready = 1'b0;
    expect_ev("sd_timeout_fetch", K_FETCH, 1, f_fetch(1));
    expect_ev("sd_timeout_fault", K_FAULT, 8, 32'h2);
    step(12);
    do_reset("reset_after_timeout");
    bus.Dmem_Ready = 1'b1;
    run_illegal("opcode_7f", 32'h0000007F);
    do_reset("reset_after_7f");
    run_illegal("slli_f3_001", 32'h00509193);
    do_reset("reset_after_slli");
    run_alu("add_recover", 32'h002081B3, 2'b10, 4'b0000, 1'b0, 0);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: got no event, required kind=%0d cyc=%0d data=%h", e.name, e.kind, e.cyc, e.data);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
